// File: rtl/run_pattern_gen.sv
// Run-length serial pattern generator: plays a queue of (bit, length) runs onto w,
// one bit per step, with z_exp predicting a four-in-a-row recognizer's output.
module run_pattern_gen #(
  parameter int RUN_W      = 4,
  parameter int DEPTH      = 8,
  parameter int DETECT_LEN = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     step,
  input  logic                     load_valid,
  input  logic                     load_bit,
  input  logic [RUN_W-1:0]         load_len,
  output logic                     load_ready,
  output logic                     w,
  output logic                     z_exp,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [CNT_W-1:0]         bit_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DETECT_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic              mem_bit [DEPTH];
  logic [RUN_W-1:0]  mem_len [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop, emit, q_nonempty;
  logic              cur_bit;
  logic [RUN_W:0]    cur_rem;
  logic [SW-1:0]     streak, streak_nxt;

  assign load_ready = (q_count != (AW + 1)'(DEPTH));
  assign push       = load_valid & load_ready;
  assign q_nonempty = (q_count != '0);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  // Pop decisions use the registered count, so a same-edge push is never popped.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    emit      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start && q_nonempty) begin
          pop       = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (step) begin
          emit = 1'b1;
          if (cur_rem == (RUN_W + 1)'(1)) begin
            if (q_nonempty) pop = 1'b1;
            else            state_nxt = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    streak_nxt = streak;
    if (streak == '0 || cur_bit != w)         streak_nxt = SW'(1);
    else if (streak != SW'(DETECT_LEN))       streak_nxt = streak + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  // NOTE: queue storage has no reset; emptiness is tracked by pointers and count alone.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_bit[wr_ptr] <= load_bit;
      mem_len[wr_ptr] <= load_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w       <= 1'b0;
      z_exp   <= 1'b0;
      streak  <= '0;
      bit_cnt <= '0;
      cur_bit <= 1'b0;
      cur_rem <= '0;
    end else begin
      if (pop) begin
        cur_bit <= mem_bit[rd_ptr];
        cur_rem <= (mem_len[rd_ptr] == '0) ? ((RUN_W + 1)'(1) << RUN_W)
                                           : {1'b0, mem_len[rd_ptr]};
      end else if (emit) begin
        cur_rem <= cur_rem - 1'b1;
      end

      if (emit) begin
        w      <= cur_bit;
        streak <= streak_nxt;
        z_exp  <= (streak_nxt == SW'(DETECT_LEN));
      end

      if (pop && state != RUN)              bit_cnt <= '0;
      else if (emit && bit_cnt != '1)       bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_run_pattern_gen.sv
// Self-checking bench for run_pattern_gen: hand tables for the directed cases and a
// queue-based reference model checked every cycle, including a random phase.
module tb_run_pattern_gen;

  logic       clk = 1'b0;
  logic       rst, start, step, load_valid, load_bit;
  logic [3:0] load_len;
  logic       load_ready, w, z_exp, busy, done;
  logic [3:0] q_count;
  logic [15:0] bit_cnt;

  int total = 0;
  int bad   = 0;

  run_pattern_gen dut (
    .clk(clk), .rst(rst), .start(start), .step(step),
    .load_valid(load_valid), .load_bit(load_bit), .load_len(load_len),
    .load_ready(load_ready), .w(w), .z_exp(z_exp), .busy(busy), .done(done),
    .q_count(q_count), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: descriptor list plus "length of the trailing run of equal bits".
  typedef struct packed { logic b; logic [3:0] len; } desc_t;
  desc_t mq[$];
  int    m_mode;      // 0 idle, 1 playing, 2 finished
  logic  m_cur_bit;
  int    m_rem;
  logic  m_w;
  int    m_run_len;
  int    m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_pop();
    desc_t d;
    d = mq.pop_front();
    m_cur_bit = d.b;
    m_rem     = (d.len == 0) ? 16 : int'(d.len);
  endtask

  task automatic model_edge();
    bit    do_push;
    desc_t nd;
    if (!rst) begin
      mq.delete();
      m_mode = 0; m_w = 0; m_run_len = 0; m_cnt = 0; m_rem = 0; m_cur_bit = 0;
      return;
    end
    do_push = load_valid && (mq.size() < 8);
    nd = '{b: load_bit, len: load_len};
    if (m_mode != 1) begin
      if (start && mq.size() > 0) begin
        m_pop();
        m_cnt  = 0;
        m_mode = 1;
      end
    end else if (step) begin
      m_run_len = (m_run_len > 0 && m_cur_bit == m_w) ? m_run_len + 1 : 1;
      m_w   = m_cur_bit;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      m_rem--;
      if (m_rem == 0) begin
        if (mq.size() > 0) m_pop();
        else               m_mode = 2;
      end
    end
    if (do_push) mq.push_back(nd);
  endtask

  task automatic model_check();
    check("m_w",     32'(w),          32'(m_w));
    check("m_z",     32'(z_exp),      32'(m_run_len >= 4));
    check("m_busy",  32'(busy),       32'(m_mode == 1));
    check("m_done",  32'(done),       32'(m_mode == 2));
    check("m_qc",    32'(q_count),    32'(mq.size()));
    check("m_ready", 32'(load_ready), 32'(mq.size() != 8));
    check("m_cnt",   32'(bit_cnt),    32'(m_cnt));
  endtask

  task automatic set_in(input logic st, input logic sp, input logic lv,
                        input logic lb, input logic [3:0] ll);
    start = st; step = sp; load_valid = lv; load_bit = lb; load_len = ll;
  endtask

  // One clock: the model consumes the inputs of this edge, outputs are sampled 1ns later.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(1, 1, 1, 1, 4'd3);
    cycle();
    cycle();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 4'd0);
  endtask

  typedef struct {
    logic st, sp, lv, lb;
    logic [3:0] ll;
    logic ew, ez, eb, ed;
    int   eq;
  } vec_t;

  vec_t vecs[18];

  initial begin
    rst = 1'b0;
    set_in(0, 0, 0, 0, 4'd0);

    // Reset with load and start asserted.
    do_reset();
    check("rst_w",     32'(w), 0);
    check("rst_z",     32'(z_exp), 0);
    check("rst_qc",    32'(q_count), 0);
    check("rst_ready", 32'(load_ready), 1);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);

    // Basic playback (1,4),(0,3) then merged run (1,2),(1,3) continuing from DONE.
    //          st sp lv lb len   w  z  b  d  qc
    vecs[0]  = '{0, 0, 1, 1, 4'd4, 0, 0, 0, 0, 1};
    vecs[1]  = '{0, 0, 1, 0, 4'd3, 0, 0, 0, 0, 2};
    vecs[2]  = '{1, 0, 0, 0, 4'd0, 0, 0, 1, 0, 1};
    vecs[3]  = '{0, 1, 0, 0, 4'd0, 1, 0, 1, 0, 1};
    vecs[4]  = '{0, 1, 0, 0, 4'd0, 1, 0, 1, 0, 1};
    vecs[5]  = '{0, 1, 0, 0, 4'd0, 1, 0, 1, 0, 1};
    vecs[6]  = '{0, 1, 0, 0, 4'd0, 1, 1, 1, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 4'd0, 0, 0, 1, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 4'd0, 0, 0, 1, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 4'd0, 0, 0, 0, 1, 0};
    vecs[10] = '{0, 0, 1, 1, 4'd2, 0, 0, 0, 1, 1};
    vecs[11] = '{0, 0, 1, 1, 4'd3, 0, 0, 0, 1, 2};
    vecs[12] = '{1, 0, 0, 0, 4'd0, 0, 0, 1, 0, 1};
    vecs[13] = '{0, 1, 0, 0, 4'd0, 1, 0, 1, 0, 1};
    vecs[14] = '{0, 1, 0, 0, 4'd0, 1, 0, 1, 0, 0};
    vecs[15] = '{0, 1, 0, 0, 4'd0, 1, 0, 1, 0, 0};
    vecs[16] = '{0, 1, 0, 0, 4'd0, 1, 1, 1, 0, 0};
    vecs[17] = '{0, 1, 0, 0, 4'd0, 1, 1, 0, 1, 0};

    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].st, vecs[i].sp, vecs[i].lv, vecs[i].lb, vecs[i].ll);
      cycle();
      check($sformatf("vec%0d_w", i),    32'(w),       32'(vecs[i].ew));
      check($sformatf("vec%0d_z", i),    32'(z_exp),   32'(vecs[i].ez));
      check($sformatf("vec%0d_busy", i), 32'(busy),    32'(vecs[i].eb));
      check($sformatf("vec%0d_done", i), 32'(done),    32'(vecs[i].ed));
      check($sformatf("vec%0d_qc", i),   32'(q_count), 32'(vecs[i].eq));
      if (i == 9) check("basic_bit_cnt", 32'(bit_cnt), 7);
    end
    set_in(0, 0, 0, 0, 4'd0);

    // Length code 0 plays 16 bits.
    do_reset();
    set_in(0, 0, 1, 1, 4'd0); cycle();
    set_in(1, 0, 0, 0, 4'd0); cycle();
    for (int k = 1; k <= 16; k++) begin
      set_in(0, 1, 0, 0, 4'd0);
      cycle();
      check($sformatf("len0_w%0d", k),    32'(w),     1);
      check($sformatf("len0_z%0d", k),    32'(z_exp), 32'(k >= 4));
      check($sformatf("len0_done%0d", k), 32'(done),  32'(k == 16));
    end
    check("len0_bit_cnt", 32'(bit_cnt), 16);
    set_in(0, 0, 0, 0, 4'd0);

    // Full queue: nine pushes, the ninth is dropped.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_in(0, 0, 1, 1'(i % 2), 4'd1);
      cycle();
    end
    check("full_qc",    32'(q_count), 8);
    check("full_ready", 32'(load_ready), 0);
    set_in(1, 0, 0, 0, 4'd0); cycle();
    check("full_start_qc", 32'(q_count), 7);
    set_in(0, 1, 1, 1, 4'd2); cycle();          // push during end-of-run pop
    check("push_pop_qc", 32'(q_count), 7);
    for (int i = 0; i < 9; i++) begin
      set_in(0, 1, 0, 0, 4'd0);
      cycle();
    end
    check("full_done",    32'(done), 1);
    check("full_bit_cnt", 32'(bit_cnt), 10);
    set_in(0, 0, 0, 0, 4'd0);

    // Reset in the middle of a run, then a start on the empty queue.
    do_reset();
    set_in(0, 0, 1, 1, 4'd6); cycle();
    set_in(1, 0, 0, 0, 4'd0); cycle();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 0, 4'd0);
      cycle();
    end
    check("mid_pre_w", 32'(w), 1);
    rst = 1'b0;
    set_in(1, 1, 1, 0, 4'd2);
    cycle();
    rst = 1'b1;
    check("mid_w",    32'(w), 0);
    check("mid_z",    32'(z_exp), 0);
    check("mid_qc",   32'(q_count), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    set_in(1, 0, 0, 0, 4'd0); cycle();
    check("mid_start_ignored", 32'(busy), 0);
    set_in(0, 0, 0, 0, 4'd0);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      set_in($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, 1'($urandom), 4'($urandom));
      cycle();
    end
    rst = 1'b1;
    set_in(0, 0, 0, 0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
